// File: rtl/ddr4_v2_2_20_axi_b_pkg.sv
// Shared constants and helpers for the AXI write-response scheduler.
package ddr4_v2_2_20_axi_b_pkg;

  localparam logic [1:0] P_OKAY   = 2'b00;
  localparam logic [1:0] P_EXOKAY = 2'b01;
  localparam logic [1:0] P_SLVERR = 2'b10;
  localparam logic [1:0] P_DECERR = 2'b11;

  localparam int P_PTR_MAX_W = 16;

  // Pointers carry a wrap bit, so the difference is taken modulo 2**ptrWidth.
  function automatic logic [P_PTR_MAX_W-1:0] ptrOccupancy(
    input logic [P_PTR_MAX_W-1:0] wrPtr,
    input logic [P_PTR_MAX_W-1:0] rdPtr,
    input int unsigned            ptrWidth
  );
    logic [P_PTR_MAX_W-1:0] mask;
    mask = (P_PTR_MAX_W'(1) << ptrWidth) - P_PTR_MAX_W'(1);
    return (wrPtr - rdPtr) & mask;
  endfunction

endpackage

// File: rtl/ddr4_v2_2_20_axi_b_sched_if.sv
// Bundle of B-channel, AW-side push and commit signals between the AXI slave and the scheduler.
interface ddr4_v2_2_20_axi_b_sched_if #(
  parameter int C_ID_WIDTH = 4
);

  logic [C_ID_WIDTH-1:0] bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic                  b_push;
  logic [C_ID_WIDTH-1:0] b_awid;
  logic                  b_full;
  logic                  wr_done;
  logic                  wr_err;
  logic                  b_cmp_err;

  modport master (
    input  bid, bresp, bvalid, b_full, b_cmp_err,
    output bready, b_push, b_awid, wr_done, wr_err
  );

  modport slave (
    output bid, bresp, bvalid, b_full, b_cmp_err,
    input  bready, b_push, b_awid, wr_done, wr_err
  );

endinterface

// File: rtl/ddr4_v2_2_20_axi_b_out_reg.sv
// B-channel output register: loads the eligible head when empty or being drained, holds otherwise.
module ddr4_v2_2_20_axi_b_out_reg
  import ddr4_v2_2_20_axi_b_pkg::*;
#(
  parameter int C_ID_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  headValid_i,
  input  logic [C_ID_WIDTH-1:0] headId_i,
  input  logic                  headErr_i,
  input  logic                  bready_i,
  output logic                  load_o,
  output logic                  bvalid_o,
  output logic [C_ID_WIDTH-1:0] bid_o,
  output logic [1:0]            bresp_o
);

  logic                  bvalid_q, bvalid_d;
  logic [C_ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;

  assign load_o = headValid_i & (~bvalid_q | bready_i);

  always_comb begin
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    if (load_o) begin
      bvalid_d = 1'b1;
      bid_d    = headId_i;
      bresp_d  = headErr_i ? P_SLVERR : P_OKAY;
    end else if (bready_i) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= P_OKAY;
    end else begin
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
    end
  end

  assign bvalid_o = bvalid_q;
  assign bid_o    = bid_q;
  assign bresp_o  = bresp_q;

endmodule

// File: rtl/ddr4_v2_2_20_axi_b_sched.sv
// In-order write-response scheduler; commit tracking and SLVERR reporting are enabled
// by defining DDR4_AXI_B_STRICT_COHERENCY_EN, otherwise responses follow the pushes.
module ddr4_v2_2_20_axi_b_sched
  import ddr4_v2_2_20_axi_b_pkg::*;
#(
  parameter int C_ID_WIDTH    = 4,
  parameter int C_FIFO_AWIDTH = 3
) (
  input logic                          clk,
  input logic                          reset,
  ddr4_v2_2_20_axi_b_sched_if.slave    bIf
);

  localparam int P_DEPTH = 2**C_FIFO_AWIDTH;
  localparam int P_PTR_W = C_FIFO_AWIDTH + 1;

  logic [P_PTR_W-1:0]    wrPtr_q, wrPtr_d;
  logic [P_PTR_W-1:0]    rdPtr_q, rdPtr_d;
  logic [C_ID_WIDTH-1:0] idMem_q [P_DEPTH];

  logic                  pushAccept;
  logic                  load;
  logic                  headValid;
  logic                  headErr;
  logic [C_ID_WIDTH-1:0] headId;

  assign bIf.b_full = (ptrOccupancy(P_PTR_MAX_W'(wrPtr_q), P_PTR_MAX_W'(rdPtr_q), P_PTR_W)
                       == P_PTR_MAX_W'(P_DEPTH));
  assign pushAccept = bIf.b_push & ~bIf.b_full;
  assign headId     = idMem_q[rdPtr_q[C_FIFO_AWIDTH-1:0]];

`ifdef DDR4_AXI_B_STRICT_COHERENCY_EN
  logic [P_PTR_W-1:0] cmpPtr_q, cmpPtr_d;
  logic               errMem_q [P_DEPTH];
  logic               cmpErr_q, cmpErr_d;
  logic               doneAccept;

  // Comparing against the registered wrPtr keeps a same-cycle push out of reach of wr_done.
  assign doneAccept = bIf.wr_done & (cmpPtr_q != wrPtr_q);
  assign headValid  = (rdPtr_q != cmpPtr_q);
  assign headErr    = errMem_q[rdPtr_q[C_FIFO_AWIDTH-1:0]];

  always_comb begin
    cmpPtr_d = cmpPtr_q + P_PTR_W'(doneAccept);
    cmpErr_d = cmpErr_q | (bIf.wr_done & ~doneAccept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmpPtr_q <= '0;
      cmpErr_q <= 1'b0;
      for (int i = 0; i < P_DEPTH; i++) errMem_q[i] <= 1'b0;
    end else begin
      cmpPtr_q <= cmpPtr_d;
      cmpErr_q <= cmpErr_d;
      if (doneAccept) errMem_q[cmpPtr_q[C_FIFO_AWIDTH-1:0]] <= bIf.wr_err;
    end
  end

  assign bIf.b_cmp_err = cmpErr_q;
`else
  logic unusedCommitInputs;

  assign unusedCommitInputs = bIf.wr_done ^ bIf.wr_err;
  assign headValid          = (rdPtr_q != wrPtr_q);
  assign headErr            = 1'b0;
  assign bIf.b_cmp_err      = 1'b0;
`endif

  always_comb begin
    wrPtr_d = wrPtr_q + P_PTR_W'(pushAccept);
    rdPtr_d = rdPtr_q + P_PTR_W'(load);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      for (int i = 0; i < P_DEPTH; i++) idMem_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      if (pushAccept) idMem_q[wrPtr_q[C_FIFO_AWIDTH-1:0]] <= bIf.b_awid;
    end
  end

  ddr4_v2_2_20_axi_b_out_reg #(
    .C_ID_WIDTH (C_ID_WIDTH)
  ) u_outReg (
    .clk         (clk),
    .reset       (reset),
    .headValid_i (headValid),
    .headId_i    (headId),
    .headErr_i   (headErr),
    .bready_i    (bIf.bready),
    .load_o      (load),
    .bvalid_o    (bIf.bvalid),
    .bid_o       (bIf.bid),
    .bresp_o     (bIf.bresp)
  );

  // Pushing into a full queue is an upstream protocol violation; the push is dropped.
  pushWhileFull: assert property (@(posedge clk) disable iff (reset) !(bIf.b_push && bIf.b_full));

endmodule

// File: tb/tb_ddr4_v2_2_20_axi_b_sched.sv
// Directed table-driven bench for the write-response scheduler; covers both builds of
// DDR4_AXI_B_STRICT_COHERENCY_EN.
module tb_ddr4_v2_2_20_axi_b_sched;

  localparam int C_ID_WIDTH    = 4;
  localparam int C_FIFO_AWIDTH = 3;
  localparam int P_DEPTH       = 2**C_FIFO_AWIDTH;

  logic clk = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;

  ddr4_v2_2_20_axi_b_sched_if #(.C_ID_WIDTH(C_ID_WIDTH)) bIf ();

  ddr4_v2_2_20_axi_b_sched #(
    .C_ID_WIDTH    (C_ID_WIDTH),
    .C_FIFO_AWIDTH (C_FIFO_AWIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bIf   (bIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic [3:0] awid;
    logic       done;
    logic       err;
    logic       bready;
    logic       expValid;
    logic [3:0] expId;
    logic [1:0] expResp;
    logic       expFull;
    logic       expCmpErr;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic push, input logic [3:0] awid, input logic done,
                        input logic err, input logic bready, input logic expValid,
                        input logic [3:0] expId, input logic [1:0] expResp,
                        input logic expFull, input logic expCmpErr);
    vec_t v;
    v = '{push, awid, done, err, bready, expValid, expId, expResp, expFull, expCmpErr};
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic push, input logic [3:0] awid, input logic done,
                               input logic err, input logic bready);
    bIf.b_push  = push;
    bIf.b_awid  = awid;
    bIf.wr_done = done;
    bIf.wr_err  = err;
    bIf.bready  = bready;
  endtask

  // bid/bresp only carry meaning while bvalid is expected high, or when checking reset values.
  task automatic checkOutput(input string tag, input logic expValid, input logic [3:0] expId,
                             input logic [1:0] expResp, input logic expFull,
                             input logic expCmpErr, input bit checkData);
    checkValue({tag, " bvalid"}, 32'(bIf.bvalid), 32'(expValid));
    checkValue({tag, " b_full"}, 32'(bIf.b_full), 32'(expFull));
    checkValue({tag, " b_cmp_err"}, 32'(bIf.b_cmp_err), 32'(expCmpErr));
    if (expValid || checkData) begin
      checkValue({tag, " bid"}, 32'(bIf.bid), 32'(expId));
      checkValue({tag, " bresp"}, 32'(bIf.bresp), 32'(expResp));
    end
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput(tag, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
`ifdef DDR4_AXI_B_STRICT_COHERENCY_EN
    //     push id  done err rdy  valid id  resp   full cmpErr
    addVec(1, 4'd5, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(0, 4'd0, 1, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   1, 4'd5, 2'b00, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(1, 4'd1, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(1, 4'd2, 1, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(1, 4'd3, 1, 1, 1,   1, 4'd1, 2'b00, 0, 0);
    addVec(0, 4'd0, 1, 0, 1,   1, 4'd2, 2'b10, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   1, 4'd3, 2'b00, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(1, 4'd6, 0, 0, 0,   0, 4'd0, 2'b00, 0, 0);
    addVec(1, 4'd7, 1, 1, 0,   0, 4'd0, 2'b00, 0, 0);
    addVec(0, 4'd0, 1, 0, 0,   1, 4'd6, 2'b10, 0, 0);
    for (int i = 0; i < 4; i++)
      addVec(0, 4'd0, 0, 0, 0, 1, 4'd6, 2'b10, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   1, 4'd7, 2'b00, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(0, 4'd0, 1, 0, 1,   0, 4'd0, 2'b00, 0, 1);
    addVec(0, 4'd0, 0, 0, 1,   0, 4'd0, 2'b00, 0, 1);
`else
    //     push id  done err rdy  valid id  resp   full cmpErr
    addVec(1, 4'd9, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(0, 4'd0, 1, 1, 1,   1, 4'd9, 2'b00, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(1, 4'd1, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(1, 4'd2, 0, 0, 1,   1, 4'd1, 2'b00, 0, 0);
    addVec(1, 4'd3, 1, 1, 1,   1, 4'd2, 2'b00, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   1, 4'd3, 2'b00, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(1, 4'd6, 0, 0, 0,   0, 4'd0, 2'b00, 0, 0);
    addVec(1, 4'd7, 0, 0, 0,   1, 4'd6, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++)
      addVec(0, 4'd0, 0, 0, 0, 1, 4'd6, 2'b00, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   1, 4'd7, 2'b00, 0, 0);
    addVec(0, 4'd0, 0, 0, 1,   0, 4'd0, 2'b00, 0, 0);
    addVec(0, 4'd0, 1, 1, 1,   0, 4'd0, 2'b00, 0, 0);
`endif

    reset = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    doReset("reset");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].push, vecs[i].awid, vecs[i].done, vecs[i].err, vecs[i].bready);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expId, vecs[i].expResp,
                  vecs[i].expFull, vecs[i].expCmpErr, 1'b0);
    end

    doReset("cmpErrClear");

`ifdef DDR4_AXI_B_STRICT_COHERENCY_EN
    // Fill the queue with uncommitted writes, then commit them back to back.
    for (int i = 0; i < P_DEPTH; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput($sformatf("fill%0d", i), 1'b0, 4'd0, 2'b00, (i == P_DEPTH - 1), 1'b0, 1'b0);
    end
    for (int i = 0; i < P_DEPTH; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      tick();
      if (i == 0)
        checkOutput("drain0", 1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0);
      else
        checkOutput($sformatf("drain%0d", i), 1'b1, 4'(i - 1), 2'b00, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("drainLast", 1'b1, 4'd7, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("drainIdle", 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
`else
    // With bready low the output register holds one entry, so nine pushes fill everything.
    for (int i = 0; i <= P_DEPTH; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("fill%0d", i), (i != 0), 4'd0, 2'b00, (i == P_DEPTH), 1'b0, 1'b0);
    end
    for (int i = 0; i <= P_DEPTH; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      tick();
      if (i < P_DEPTH)
        checkOutput($sformatf("drain%0d", i), 1'b1, 4'(i + 1), 2'b00, 1'b0, 1'b0, 1'b0);
      else
        checkOutput("drainIdle", 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    end
`endif

    // Reset with responses outstanding and bvalid high.
    doReset("preMidOp");
    applyStimulus(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd11, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd12, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("midOpBusy", 1'b1, 4'd10, 2'b00, 1'b0, 1'b0, 1'b0);
    doReset("midOpReset");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput($sformatf("noStale%0d", i), 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    end

    // A fresh transaction after reset must come out with the normal latency.
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("postReset0", 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
`ifdef DDR4_AXI_B_STRICT_COHERENCY_EN
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("postReset1", 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
`endif
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("postResetResp", 1'b1, 4'd4, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("postResetIdle", 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ddr4_v2_2_20_axi_b_sched.md
# ddr4_v2_2_20_axi_b_sched

Write-response scheduler for the AXI slave. It sits between the write-address channel, which pushes the AWID of each accepted write, and the AXI B channel. It holds each response until the memory controller reports that write as committed, then returns BID and BRESP in order. Committed-with-error writes return SLVERR.

## Interface
Parameters:
- C_ID_WIDTH, 4, width of AWID/BID (>= 1)
- C_FIFO_AWIDTH, 3, log2 of ID queue depth; P_DEPTH = 2**C_FIFO_AWIDTH

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- bid  output  C_ID_WIDTH  AXI response ID
- bresp  output  2  AXI response; OKAY 2'b00 or SLVERR 2'b10
- bvalid  output  1  AXI response valid
- bready  input  1  AXI response ready
- b_push  input  1  enqueue b_awid (one per accepted write)
- b_awid  input  C_ID_WIDTH  ID to enqueue
- b_full  output  1  ID queue full; push must not be asserted
- wr_done  input  1  one pulse per committed write, in AW order
- wr_err  input  1  qualifies wr_done; write committed with error
- b_cmp_err  output  1  sticky: wr_done seen with no uncommitted entry

## Operation
- Circular queue of P_DEPTH entries, each holding {id, err}. It has three pointers, each C_FIFO_AWIDTH+1 bits wide with a wrap bit:
  - wr_ptr advances on push.
  - cmp_ptr advances on wr_done and writes err[cmp_ptr] = wr_err.
  - rd_ptr advances when the head entry loads into the output register.
- Occupancy = wr_ptr - rd_ptr (modulo). b_full = (occupancy == P_DEPTH). This is combinational from the registered pointers.
- Head is eligible when rd_ptr != cmp_ptr, i.e. the head write is committed.
- Output register {bvalid, bid, bresp} loads the eligible head when (!bvalid | bready):
  - bresp = err ? 2'b10 : 2'b00.
  - If no entry is eligible, bvalid clears on bready.
- Handshake: once bvalid is high, bid and bresp stay stable until bvalid & bready.
- Total outstanding capacity is P_DEPTH + 1 (queue plus output register).

Boundary conditions:
- Push while b_full: ignored, no pointer change. This is a protocol violation; covered by an assertion.
- wr_done while cmp_ptr == wr_ptr: ignored, b_cmp_err set until reset.
- Push and wr_done in the same cycle: the wr_done commits the oldest already-queued uncommitted entry, never the one being pushed.
- Push, load and wr_done in the same cycle: all three pointers update independently.
- Reset mid-operation: all pointers, contents and the output register are cleared; outstanding responses are discarded.

## Timing
- Reset values: bvalid 0, bid 0, bresp 2'b00, b_full 0, b_cmp_err 0.
- Latency with the macro defined: wr_done sampled at edge E0, cmp_ptr updates at E0, the head loads at E1, so bvalid is high in the second cycle after the wr_done cycle.
- The push must precede or coincide with the earliest permitted wr_done.
- Throughput: one response per cycle while bready = 1 and committed entries exist.
- b_full deasserts the cycle after the load that frees a slot.

## Configuration
- DDR4_AXI_B_STRICT_COHERENCY_EN defined:
  - Eligibility requires commit (rd_ptr != cmp_ptr).
  - bresp reflects wr_err.
  - b_cmp_err is active.
- Not defined:
  - cmp_ptr and the err storage are removed; eligibility is rd_ptr != wr_ptr.
  - wr_done and wr_err are ignored; bresp is constant 2'b00; b_cmp_err is tied 0.
  - bvalid rises in the second cycle after the b_push cycle.

## Structure
- Package ddr4_v2_2_20_axi_b_pkg holds:
  - Response constants P_OKAY, P_EXOKAY, P_SLVERR, P_DECERR.
  - Pointer-occupancy helper function.
- One sub-module, ddr4_v2_2_20_axi_b_out_reg: the output register with the load/hold rule.
- Queue and pointers stay inline in the top module, since three pointers do not fit the generic FIFO.

## Test plan
- Push id 5, wr_done 3 cycles later, bready = 1 -> bvalid high in the second cycle after wr_done for exactly 1 cycle, bid = 5, bresp = 2'b00.
- Push ids 0..7 with no wr_done -> b_full = 1 after the 8th push and bvalid stays 0. Then 8 back-to-back wr_done with bready = 1 -> bid 0..7 on 8 consecutive cycles; b_full = 0 after the first load.
- Three pushes (ids 1, 2, 3); wr_done with wr_err = 1 on the second completion only -> responses (1, 00), (2, 10), (3, 00).
- bready held 0 for 5 cycles with 2 committed entries -> bvalid, bid and bresp stable. Release bready -> 2 responses on consecutive cycles.
- wr_done with an empty queue -> b_cmp_err = 1 from the next cycle, no bvalid. Reset -> b_cmp_err = 0.
- Reset asserted with 4 entries queued and bvalid high -> all outputs at reset values the next cycle, and no stale response after reset.
- Macro undefined: push id 9 -> bid 9 with bvalid high in the second cycle after the push, bresp 2'b00, no wr_done needed.
